reg_share_arbiter: RTL and testbench
====================================

// Module: reg_share_arbiter
// PURPOSE
//  Shares one WIDTH-bit storage register among N requesters.
//  Arbitration is round-robin. Any requester may lock the register for a multi-cycle burst.
//  The register has a global synchronous clear: the clr_req path mirrors the DFF init input.
//  Sits between client blocks and the shared state register. Its job is to make exactly one
//  write, or one clear, happen per clock edge.
// PARAMETERS
//  N      4   number of requesters (>=2)
//  WIDTH  8   width of the shared register and of each requester's write data
//  IDW    $clog2(N)   requester-index width (derived, not overridable)
// PORTS
//  clk      in   1          rising-edge clock
//  Re       in   1          asynchronous reset, active-low
//  req      in   N          req[i]=1: requester i wants to write wdata slice i
//  wdata    in   N*WIDTH    slice i = wdata[i*WIDTH +: WIDTH]
//  lock     in   N          lock[i]=1 with a granted write: keep ownership afterwards
//  clr_req  in   1          synchronous clear request (highest priority)
//  q        out  WIDTH      shared register contents
//  gnt      out  N          one-hot; marks the requester whose write landed at the last edge
//  owner    out  IDW        index of the last granted requester
//  locked   out  1          1 while the FSM is in LOCKED
//  upd      out  1          1 for one cycle after a write edge
//  clr_ack  out  1          1 for one cycle after a clear edge
// BEHAVIOUR
//  Reset (Re=0, async): q=0, gnt=0, owner=0, ptr=0, state=FREE, upd=0, clr_ack=0, locked=0.
//    Deassertion takes effect at the next edge.
//  All outputs are registered. Decision and write share the same edge, so latency is 1 edge.
//  FSM states:
//    FREE   : eligible set = all req bits
//    LOCKED : eligible set = req[owner] only; other requesters stall, no starvation counter
//  Per edge, first matching rule applies:
//    1. clr_req=1
//       - q<=0, clr_ack<=1, gnt<=0, upd<=0, state<=FREE
//       - ptr and owner unchanged; any pending write is dropped
//    2. eligible set non-empty
//       - w = first index >= ptr in eligible set, searching cyclically (wraps N-1 -> 0)
//       - q<=wdata slice w; gnt<=onehot(w); owner<=w; upd<=1; ptr<=(w+1) mod N
//       - state<=LOCKED if lock[w]=1, else FREE
//    3. otherwise
//       - gnt<=0, upd<=0, q holds
//       - In LOCKED with lock[owner]=0: state<=FREE; else state holds
//  Handshake:
//    - A requester keeps req high until it sees its gnt bit.
//    - A req still high in the gnt cycle counts as a new request. It wins again only when it
//      is eligible and ptr comes back to it, or when it holds the lock.
//  Lock release:
//    - A write by the owner with lock=0 frees the register (rule 2).
//    - Idle with lock[owner]=0 also frees it (rule 3).
//  N not a power of 2: ptr wraps at N; indices >= N are never granted.
//  q width equals WIDTH. No data arithmetic is done; only the pointer increment, modulo N.
//  clr_req together with any req: the clear wins, and requesters must hold req.
//  Reset asserted mid-burst: lock is lost; requesters must re-request after reset.
// STRUCTURE
//  Shared package reg_share_pkg:
//    - state enum {FREE, LOCKED}
//    - default N/WIDTH localparams
//    - function rr_pick(req, ptr) returning index and found flag
//  Sub-module shared_reg:
//    - WIDTH-bit storage with async active-low Re, synchronous clr (init) and enable
//    - Built per bit from the team's master-slave DFF cell
//  Top level holds the FSM, ptr, owner and output registers.
// TESTING (N=4, WIDTH=8)
//  1. Re=0 then 1; req=0, clr_req=0 for 3 cycles -> q=0x00, gnt=0, owner=0, locked=0, upd=0 throughout.
//  2. req=4'b1111 held; wdata slices = {0x44,0x33,0x22,0x11}
//     -> gnt sequence 0001,0010,0100,1000,0001; q = 0x11,0x22,0x33,0x44,0x11.
//  3. req[1]=1 with lock[1]=1 plus req[2]=1
//     -> gnt=0010, locked=1; req[2] stalls while req[1] writes 3x.
//     Then lock[1]=0 on the 4th write -> locked=0; next edge gnt=0100.
//  4. req=4'b0101, clr_req=1 at the same edge -> q=0x00, clr_ack=1, gnt=0.
//     Next edge (clr_req=0) -> gnt=0001 (ptr unchanged).
//  5. ptr=3, req=4'b0001 -> gnt=0001 (wrap-around); ptr becomes 1.
//  6. Re pulsed low mid-cycle while locked=1, q=0xA5
//     -> all outputs zero immediately, no clk edge needed; state FREE after release.

Source files
------------

// File: rtl/reg_share_pkg.sv
// Shared types and the round-robin pick helper for the shared-register arbiter.
// Combinational helpers only; no state lives here.
package reg_share_pkg;

    localparam int RS_N_DEF     = 4;
    localparam int RS_WIDTH_DEF = 8;
    localparam int RS_MAX_N     = 32;
    localparam int RS_IDX_W     = 5;

    typedef enum logic [0:0] {
        FREE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic                found;
        logic [RS_IDX_W-1:0] idx;
    } pick_t;

    // First set bit at or after ptr, wrapping at n rather than at RS_MAX_N.
    function automatic pick_t rr_pick(input logic [RS_MAX_N-1:0] req,
                                      input logic [RS_IDX_W-1:0] ptr,
                                      input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < RS_MAX_N; k++) begin
            if (k < n && !p.found) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (req[RS_IDX_W'(j)]) begin
                    p.found = 1'b1;
                    p.idx   = RS_IDX_W'(j);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/shared_reg.sv
// WIDTH-bit storage built bit by bit; synchronous clear beats enable.
// Latency 1 edge; no backpressure.
module shared_reg
    import reg_share_pkg::*;
#(
    parameter int WIDTH = RS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic r_bit;

        always_ff @(posedge clk or negedge Re) begin
            if (!Re) begin
                r_bit <= 1'b0;
            end else if (i_clr) begin
                r_bit <= 1'b0;
            end else if (i_en) begin
                r_bit <= i_d[b];
            end
        end

        assign o_q[b] = r_bit;
    end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter with burst lock and global clear in front of one shared register.
// Latency 1 edge; no backpressure, losing requesters hold req until they see their gnt bit.
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter  int N     = RS_N_DEF,
    parameter  int WIDTH = RS_WIDTH_DEF,
    localparam int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               Re,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] wdata,
    input  logic [N-1:0]       lock,
    input  logic               clr_req,
    output logic [WIDTH-1:0]   q,
    output logic [N-1:0]       gnt,
    output logic [IDW-1:0]     owner,
    output logic               locked,
    output logic               upd,
    output logic               clr_ack
);

    state_e           r_state;
    logic [N-1:0]     r_gnt;
    logic [IDW-1:0]   r_owner;
    logic [IDW-1:0]   r_ptr;
    logic             r_upd;
    logic             r_clr_ack;

    logic [N-1:0]     w_elig;
    pick_t            w_pick;
    logic [IDW-1:0]   w_win;
    logic             w_write;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_din;

    // While locked only the owner may write; everyone else stalls.
    always_comb begin
        w_elig = req;
        if (r_state == LOCKED) begin
            w_elig = req & (N'(1) << r_owner);
        end
    end

    assign w_pick    = rr_pick(RS_MAX_N'(w_elig), RS_IDX_W'(r_ptr), N);
    assign w_win     = w_pick.idx[IDW-1:0];
    assign w_write   = w_pick.found & ~clr_req;
    assign w_ptr_nxt = (w_win == IDW'(N - 1)) ? '0 : w_win + IDW'(1);
    assign w_din     = wdata[w_win*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge Re) begin
        if (!Re) begin
            r_state   <= FREE;
            r_gnt     <= '0;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_upd     <= 1'b0;
            r_clr_ack <= 1'b0;
        end else if (clr_req) begin
            r_state   <= FREE;
            r_gnt     <= '0;
            r_upd     <= 1'b0;
            r_clr_ack <= 1'b1;
        end else if (w_pick.found) begin
            r_state   <= lock[w_win] ? LOCKED : FREE;
            r_gnt     <= N'(1) << w_win;
            r_owner   <= w_win;
            r_ptr     <= w_ptr_nxt;
            r_upd     <= 1'b1;
            r_clr_ack <= 1'b0;
        end else begin
            r_gnt     <= '0;
            r_upd     <= 1'b0;
            r_clr_ack <= 1'b0;
            if (r_state == LOCKED && !lock[r_owner]) begin
                r_state <= FREE;
            end
        end
    end

    shared_reg #(.WIDTH(WIDTH)) u_shared_reg (
        .clk   (clk),
        .Re    (Re),
        .i_clr (clr_req),
        .i_en  (w_write),
        .i_d   (w_din),
        .o_q   (q)
    );

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign locked  = (r_state == LOCKED);
    assign upd     = r_upd;
    assign clr_ack = r_clr_ack;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Randomized and directed bench for reg_share_arbiter against a behavioural model (N=4, WIDTH=8).
module tb_reg_share_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic               clk = 1'b0;
    logic               Re  = 1'b0;
    logic [N-1:0]       req = '0;
    logic [N*WIDTH-1:0] wdata = '0;
    logic [N-1:0]       lock = '0;
    logic               clr_req = 1'b0;
    logic [WIDTH-1:0]   q;
    logic [N-1:0]       gnt;
    logic [IDW-1:0]     owner;
    logic               locked;
    logic               upd;
    logic               clr_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int   m_q, m_gnt, m_owner, m_ptr;
    bit   m_locked, m_upd, m_ack;

    reg_share_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .Re      (Re),
        .req     (req),
        .wdata   (wdata),
        .lock    (lock),
        .clr_req (clr_req),
        .q       (q),
        .gnt     (gnt),
        .owner   (owner),
        .locked  (locked),
        .upd     (upd),
        .clr_ack (clr_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = 0; m_gnt = 0; m_owner = 0; m_ptr = 0;
        m_locked = 0; m_upd = 0; m_ack = 0;
    endtask

    task automatic model_edge();
        int  w;
        int  idx;
        w = -1;
        if (clr_req) begin
            m_q = 0; m_ack = 1; m_gnt = 0; m_upd = 0; m_locked = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (w < 0 && req[idx] && (!m_locked || idx == m_owner)) w = idx;
            end
            m_ack = 0;
            if (w >= 0) begin
                m_q      = int'(wdata[w*WIDTH +: WIDTH]);
                m_gnt    = 1 << w;
                m_owner  = w;
                m_upd    = 1;
                m_ptr    = (w + 1) % N;
                m_locked = lock[w];
            end else begin
                m_gnt = 0;
                m_upd = 0;
                if (m_locked && !lock[m_owner]) m_locked = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".q"},      32'(q),       32'(m_q));
        check({tag, ".gnt"},    32'(gnt),     32'(m_gnt));
        check({tag, ".owner"},  32'(owner),   32'(m_owner));
        check({tag, ".locked"}, 32'(locked),  32'(m_locked));
        check({tag, ".upd"},    32'(upd),     32'(m_upd));
        check({tag, ".clr_ack"},32'(clr_ack), 32'(m_ack));
    endtask

    // Apply inputs, take one edge, then compare DUT with model 1ns later.
    task automatic step(input string tag, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic clr, input logic [N*WIDTH-1:0] wd);
        req = rq; lock = lk; clr_req = clr; wdata = wd;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [N-1:0]       exp_g [5];
    logic [WIDTH-1:0]   exp_q [5];

    initial begin
        model_reset();
        // Reset state
        #1;
        check("rst.q", 32'(q), 32'h0);
        check("rst.gnt", 32'(gnt), 32'h0);
        check("rst.locked", 32'(locked), 32'h0);
        #11 Re = 1'b1;
        for (int i = 0; i < 3; i++) step("idle", 4'b0000, 4'b0000, 1'b0, 32'h0);

        // Plain round robin
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
        for (int i = 0; i < 5; i++) begin
            step("rr", 4'b1111, 4'b0000, 1'b0, 32'h44332211);
            check("rr.gnt_seq", 32'(gnt), 32'(exp_g[i]));
            check("rr.q_seq", 32'(q), 32'(exp_q[i]));
        end

        // Lock burst by requester 1 while requester 2 waits
        step("lk1", 4'b0110, 4'b0010, 1'b0, 32'h00_C3_B1_00);
        check("lk.gnt", 32'(gnt), 32'h2);
        check("lk.locked", 32'(locked), 32'h1);
        step("lk2", 4'b0110, 4'b0010, 1'b0, 32'h00_C3_B2_00);
        step("lk3", 4'b0110, 4'b0010, 1'b0, 32'h00_C3_B3_00);
        check("lk.stall_gnt", 32'(gnt), 32'h2);
        step("lk4", 4'b0110, 4'b0000, 1'b0, 32'h00_C3_B4_00);
        check("lk.release", 32'(locked), 32'h0);
        step("lk5", 4'b0110, 4'b0000, 1'b0, 32'h00_C3_B5_00);
        check("lk.next_gnt", 32'(gnt), 32'h4);

        // Clear collides with requests
        step("clr", 4'b0101, 4'b0000, 1'b1, 32'h00_77_00_66);
        check("clr.ack", 32'(clr_ack), 32'h1);
        check("clr.q", 32'(q), 32'h0);
        step("clr_after", 4'b0101, 4'b0000, 1'b0, 32'h00_77_00_66);
        check("clr.ptr_kept", 32'(gnt), 32'h1);

        // Wrap from ptr=3 to index 0
        step("wrap_a", 4'b0100, 4'b0000, 1'b0, 32'h00_5A_00_00);
        step("wrap_b", 4'b0001, 4'b0000, 1'b0, 32'h00_00_00_E1);
        check("wrap.gnt", 32'(gnt), 32'h1);
        step("wrap_c", 4'b1111, 4'b0000, 1'b0, 32'h01_02_03_04);
        check("wrap.ptr1", 32'(gnt), 32'h2);

        // Asynchronous reset mid-burst
        step("ar_lock", 4'b0010, 4'b0010, 1'b0, 32'h00_00_A5_00);
        check("ar.pre_q", 32'(q), 32'hA5);
        #2 Re = 1'b0;
        #1;
        check("ar.q", 32'(q), 32'h0);
        check("ar.locked", 32'(locked), 32'h0);
        check("ar.gnt", 32'(gnt), 32'h0);
        check("ar.upd", 32'(upd), 32'h0);
        model_reset();
        #1 Re = 1'b1;
        step("ar_after", 4'b0001, 4'b0000, 1'b0, 32'h00_00_00_3C);
        check("ar.after_gnt", 32'(gnt), 32'h1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 4'($urandom),
                 4'($urandom) & 4'($urandom),
                 ($urandom_range(0, 15) == 0),
                 32'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
